xy_switch_rr: RTL and testbench



---
 rtl/xy_switch_rr.sv | 201 ++++++++++++++++++++
 tb/tb_xy_switch_rr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/xy_switch_rr.sv
// Five-port XY mesh router with a FIFO on each input and a round-robin arbiter on each output.
// Edge ports that face off the mesh are tied off. Packets addressed outside the mesh are discarded.
module xy_switch_rr #(
    parameter int COL_CORD     = 0,
    parameter int ROW_CORD     = 0,
    parameter int MESH_COLS    = 4,
    parameter int MESH_ROWS    = 4,
    parameter int FIFO_DEPTH_W = 3,
    parameter int COL_ADDR_W   = 4,
    parameter int ROW_ADDR_W   = 4,
    parameter int PCKT_DATA_W  = 8,
    parameter int PCKT_W       = COL_ADDR_W + ROW_ADDR_W + PCKT_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [4:0]          wr_en_sw_i,
    input  logic [5*PCKT_W-1:0] pckt_sw_i,
    output logic [4:0]          in_fifo_full_o,
    output logic [4:0]          in_fifo_overflow_o,
    output logic [4:0]          drop_o,
    input  logic [4:0]          nxt_fifo_full_i,
    output logic [4:0]          wr_en_sw_o,
    output logic [5*PCKT_W-1:0] pckt_sw_o
);

    localparam int PORT_N  = 5;
    localparam int DEPTH   = 1 << FIFO_DEPTH_W;
    localparam int CNT_W   = FIFO_DEPTH_W + 1;
    localparam int P_RES   = 0;
    localparam int P_NORTH = 1;
    localparam int P_EAST  = 2;
    localparam int P_SOUTH = 3;
    localparam int P_WEST  = 4;

    localparam logic [PORT_N-1:0] PORT_EN = {
        (COL_CORD != 0), (ROW_CORD != MESH_ROWS - 1), (COL_CORD != MESH_COLS - 1),
        (ROW_CORD != 0), 1'b1
    };

    logic [PCKT_W-1:0] head [PORT_N];
    logic [PORT_N-1:0] not_empty;
    logic [PORT_N-1:0] drop_c;
    logic [PORT_N-1:0] pop;
    logic [PORT_N-1:0] req [PORT_N];   // req[input][output]
    logic [PORT_N-1:0] gnt [PORT_N];   // gnt[output][input]

    always_comb begin
        pop = drop_c;
        for (int o = 0; o < PORT_N; o++) begin
            pop = pop | gnt[o];
        end
    end

    // Inputs are push-only: a write strobe is taken when in_fifo_full_o is low,
    // otherwise the packet is lost and flagged; outputs likewise push whenever nxt_fifo_full_i is low.
    for (genvar p = 0; p < PORT_N; p++) begin : g_in
        if (PORT_EN[p]) begin : g_fifo
            logic [PCKT_W-1:0]       mem [DEPTH];
            logic [FIFO_DEPTH_W-1:0] wr_ptr;
            logic [FIFO_DEPTH_W-1:0] rd_ptr;
            logic [CNT_W-1:0]        cnt;
            logic [CNT_W-1:0]        cnt_nxt;
            logic                    full_q;
            logic                    ovf_q;
            logic                    drop_q;
            logic                    push;

            assign push    = wr_en_sw_i[p] & ~full_q;
            assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop[p]);

            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem[wr_ptr] <= pckt_sw_i[p*PCKT_W +: PCKT_W];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    full_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    drop_q <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop[p]) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    cnt    <= cnt_nxt;
                    full_q <= (cnt_nxt == CNT_W'(DEPTH));
                    ovf_q  <= wr_en_sw_i[p] & full_q;
                    drop_q <= drop_c[p];
                end
            end

            assign head[p]               = mem[rd_ptr];
            assign not_empty[p]          = (cnt != '0);
            assign in_fifo_full_o[p]     = full_q;
            assign in_fifo_overflow_o[p] = ovf_q;
            assign drop_o[p]             = drop_q;
        end else begin : g_off
            logic unused_port;
            assign unused_port = ^{wr_en_sw_i[p], pckt_sw_i[p*PCKT_W +: PCKT_W], pop[p], drop_c[p]};

            assign head[p]               = '0;
            assign not_empty[p]          = 1'b0;
            assign in_fifo_full_o[p]     = 1'b1;
            assign in_fifo_overflow_o[p] = 1'b0;
            assign drop_o[p]             = 1'b0;
        end
    end

    for (genvar i = 0; i < PORT_N; i++) begin : g_route
        logic [COL_ADDR_W-1:0] dcol;
        logic [ROW_ADDR_W-1:0] drow;
        logic                  off_mesh;
        logic [PORT_N-1:0]     dir;

        assign dcol     = head[i][PCKT_W-1 -: COL_ADDR_W];
        assign drow     = head[i][PCKT_W-COL_ADDR_W-1 -: ROW_ADDR_W];
        assign off_mesh = (32'(dcol) >= MESH_COLS) || (32'(drow) >= MESH_ROWS);

        // X is resolved fully before Y.
        always_comb begin
            dir = '0;
            if (32'(dcol) > COL_CORD) begin
                dir[P_EAST] = 1'b1;
            end else if (32'(dcol) < COL_CORD) begin
                dir[P_WEST] = 1'b1;
            end else if (32'(drow) > ROW_CORD) begin
                dir[P_SOUTH] = 1'b1;
            end else if (32'(drow) < ROW_CORD) begin
                dir[P_NORTH] = 1'b1;
            end else begin
                dir[P_RES] = 1'b1;
            end
        end

        assign drop_c[i] = not_empty[i] & off_mesh;
        assign req[i]    = (not_empty[i] & ~off_mesh) ? (dir & PORT_EN) : '0;
    end

    for (genvar o = 0; o < PORT_N; o++) begin : g_out
        logic [2:0]        rr_ptr;
        logic [2:0]        idx;
        logic [2:0]        gidx;
        logic              found;
        logic [PORT_N-1:0] g;
        logic              v1;
        logic              v2;
        logic [PCKT_W-1:0] d1;
        logic [PCKT_W-1:0] d2;

        // Scan starting at rr_ptr; the first requester found wins.
        always_comb begin
            g     = '0;
            found = 1'b0;
            gidx  = '0;
            idx   = '0;
            if (!nxt_fifo_full_i[o]) begin
                for (int k = 0; k < PORT_N; k++) begin
                    idx = 3'((32'(rr_ptr) + 32'(k)) % PORT_N);
                    if (!found && req[idx][o]) begin
                        found  = 1'b1;
                        gidx   = idx;
                        g[idx] = 1'b1;
                    end
                end
            end
        end

        assign gnt[o] = g;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_ptr <= '0;
                v1     <= 1'b0;
                d1     <= '0;
                v2     <= 1'b0;
                d2     <= '0;
            end else begin
                if (found) begin
                    rr_ptr <= (gidx == 3'(PORT_N - 1)) ? 3'd0 : gidx + 3'd1;
                    d1     <= head[gidx];
                end
                v1 <= found;
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                end
            end
        end

        assign wr_en_sw_o[o]                 = v2;
        assign pckt_sw_o[o*PCKT_W +: PCKT_W] = d2;
    end

endmodule

// File: tb/tb_xy_switch_rr.sv
// Directed bench for xy_switch_rr: a node at (1,1) in a 4x4 mesh plus a corner node at (0,0).
// Output packets are checked against per-output expected queues as they appear.
module tb_xy_switch_rr;

    localparam int PW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      wr_en_i, nxt_full, full_o, ovf_o, drop_o, wr_en_o;
    logic [5*PW-1:0] pckt_i, pckt_o;
    logic [4:0]      e_wr_en_i, e_nxt_full, e_full_o, e_ovf_o, e_drop_o, e_wr_en_o;
    logic [5*PW-1:0] e_pckt_i, e_pckt_o;

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] exp_q [5][$];
    logic [5*PW-1:0] exp_vec;

    xy_switch_rr #(.COL_CORD(1), .ROW_CORD(1), .MESH_COLS(4), .MESH_ROWS(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_sw_i(wr_en_i), .pckt_sw_i(pckt_i),
        .in_fifo_full_o(full_o), .in_fifo_overflow_o(ovf_o), .drop_o(drop_o),
        .nxt_fifo_full_i(nxt_full), .wr_en_sw_o(wr_en_o), .pckt_sw_o(pckt_o)
    );

    xy_switch_rr #(.COL_CORD(0), .ROW_CORD(0), .MESH_COLS(4), .MESH_ROWS(4)) u_edge (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_sw_i(e_wr_en_i), .pckt_sw_i(e_pckt_i),
        .in_fifo_full_o(e_full_o), .in_fifo_overflow_o(e_ovf_o), .drop_o(e_drop_o),
        .nxt_fifo_full_i(e_nxt_full), .wr_en_sw_o(e_wr_en_o), .pckt_sw_o(e_pckt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(input int dc, input int dr, input int d);
        return {4'(dc), 4'(dr), 8'(d)};
    endfunction

    task automatic chk(input string tag, input logic [5*PW-1:0] obs, input logic [5*PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [PW-1:0] pkt);
        wr_en_i[p] = 1'b1;
        pckt_i[p*PW +: PW] = pkt;
    endtask

    task automatic push_exp(input int o, input logic [PW-1:0] pkt);
        exp_q[o].push_back(pkt);
    endtask

    // Scoreboard: every output write must match the oldest expected packet of that output.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                if (wr_en_o[o]) begin
                    if (exp_q[o].size() == 0) begin
                        chk("out_unexpected", 80'(wr_en_o[o]), 80'(0));
                    end else begin
                        chk("out_data", 80'(pckt_o[o*PW +: PW]), 80'(exp_q[o].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wr_en_i = '0; pckt_i = '0; nxt_full = '0;
        e_wr_en_i = '0; e_pckt_i = '0; e_nxt_full = '0;
        step; step;

        // Reset state
        chk("rst_wr_en", 80'(wr_en_o), 80'(0));
        chk("rst_pckt", pckt_o, 80'(0));
        chk("rst_full", 80'(full_o), 80'(0));
        chk("rst_ovf", 80'(ovf_o), 80'(0));
        chk("rst_drop", 80'(drop_o), 80'(0));
        chk("rst_edge_full", 80'(e_full_o), 80'(5'b10010));
        rst_n = 1'b1;
        step;

        // Single route, latency 2
        drive(0, pk(3, 1, 'hA5));
        push_exp(2, pk(3, 1, 'hA5));
        step;
        wr_en_i = '0;
        chk("t1_k0", 80'(wr_en_o), 80'(0));
        step;
        chk("t1_k1", 80'(wr_en_o), 80'(0));
        step;
        chk("t1_k2", 80'(wr_en_o), 80'(5'b00100));
        exp_vec = '0;
        exp_vec[2*PW +: PW] = pk(3, 1, 'hA5);
        chk("t1_pckt", pckt_o, exp_vec);
        step;
        chk("t1_k3", 80'(wr_en_o), 80'(0));

        // Round-robin on RESOURCE
        for (int p = 1; p <= 3; p++) begin
            drive(p, pk(1, 1, p * 16 + 1));
            push_exp(0, pk(1, 1, p * 16 + 1));
        end
        step;
        for (int p = 1; p <= 3; p++) begin
            drive(p, pk(1, 1, p * 16 + 2));
            push_exp(0, pk(1, 1, p * 16 + 2));
        end
        step;
        wr_en_i = '0;
        chk("t2_pre", 80'(wr_en_o), 80'(0));
        for (int i = 0; i < 6; i++) begin
            step;
            chk("t2_rr_slot", 80'(wr_en_o), 80'(5'b00001));
        end
        step;
        chk("t2_post", 80'(wr_en_o), 80'(0));

        // Backpressure and overflow
        nxt_full[2] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(0, pk(3, 1, 'h80 + i));
            if (i < 8) push_exp(2, pk(3, 1, 'h80 + i));
            step;
            chk("t3_full", 80'(full_o[0]), 80'(i >= 7));
            chk("t3_ovf", 80'(ovf_o[0]), 80'(i == 8));
            chk("t3_blocked", 80'(wr_en_o), 80'(0));
        end
        wr_en_i = '0;
        step;
        chk("t3_ovf_end", 80'(ovf_o), 80'(0));
        chk("t3_full_hold", 80'(full_o), 80'(5'b00001));
        nxt_full[2] = 1'b0;
        step;
        chk("t3_full_clear", 80'(full_o), 80'(0));
        chk("t3_rel_pre", 80'(wr_en_o), 80'(0));
        for (int i = 0; i < 8; i++) begin
            step;
            chk("t3_drain", 80'(wr_en_o), 80'(5'b00100));
        end
        step;
        chk("t3_drain_end", 80'(wr_en_o), 80'(0));

        // Out-of-mesh drop
        drive(3, pk(5, 1, 'hD0));
        step;
        wr_en_i = '0;
        chk("t4_drop_k0", 80'(drop_o), 80'(0));
        step;
        chk("t4_drop_k1", 80'(drop_o), 80'(5'b01000));
        chk("t4_wr_k1", 80'(wr_en_o), 80'(0));
        step;
        chk("t4_drop_k2", 80'(drop_o), 80'(0));
        chk("t4_wr_k2", 80'(wr_en_o), 80'(0));
        drive(3, pk(1, 1, 'hD1));
        push_exp(0, pk(1, 1, 'hD1));
        step;
        wr_en_i = '0;
        step; step;
        chk("t4_follow", 80'(wr_en_o), 80'(5'b00001));
        step;
        chk("t4_follow_end", 80'(wr_en_o), 80'(0));

        // Corner node: NORTH and WEST are off-mesh
        e_wr_en_i = 5'b10011;
        e_pckt_i[0*PW +: PW] = pk(1, 0, 'h50);
        e_pckt_i[1*PW +: PW] = pk(0, 0, 'h51);
        e_pckt_i[4*PW +: PW] = pk(0, 0, 'h54);
        step;
        e_wr_en_i = '0;
        chk("t5_ovf_k0", 80'(e_ovf_o), 80'(0));
        chk("t5_full", 80'(e_full_o), 80'(5'b10010));
        step;
        chk("t5_ovf_k1", 80'(e_ovf_o), 80'(0));
        chk("t5_wr_k1", 80'(e_wr_en_o), 80'(0));
        step;
        chk("t5_wr_k2", 80'(e_wr_en_o), 80'(5'b00100));
        exp_vec = '0;
        exp_vec[2*PW +: PW] = pk(1, 0, 'h50);
        chk("t5_pckt", e_pckt_o, exp_vec);
        step;
        chk("t5_wr_k3", 80'(e_wr_en_o), 80'(0));
        step;
        chk("t5_wr_k4", 80'(e_wr_en_o), 80'(0));

        // Mid-traffic reset
        nxt_full[0] = 1'b1;
        drive(1, pk(1, 1, 'hE1));
        drive(2, pk(1, 1, 'hE2));
        drive(4, pk(1, 1, 'hE4));
        step;
        wr_en_i = '0;
        step;
        chk("t6_held", 80'(wr_en_o), 80'(0));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr", 80'(wr_en_o), 80'(0));
        chk("t6_rst_pckt", pckt_o, 80'(0));
        chk("t6_rst_full", 80'(full_o), 80'(0));
        chk("t6_rst_ovf", 80'(ovf_o), 80'(0));
        chk("t6_rst_drop", 80'(drop_o), 80'(0));
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        step; step;
        rst_n = 1'b1;
        nxt_full = '0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("t6_no_stale", 80'(wr_en_o), 80'(0));
        end
        drive(4, pk(1, 1, 'h41));
        drive(1, pk(1, 1, 'h14));
        push_exp(0, pk(1, 1, 'h14));
        push_exp(0, pk(1, 1, 'h41));
        step;
        wr_en_i = '0;
        step; step;
        chk("t6_first", 80'(wr_en_o), 80'(5'b00001));
        step;
        chk("t6_second", 80'(wr_en_o), 80'(5'b00001));
        step;
        chk("t6_end", 80'(wr_en_o), 80'(0));

        step;
        for (int o = 0; o < 5; o++) begin
            chk("queue_empty", 80'(exp_q[o].size()), 80'(0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
